// File: rtl/ss_decoder_5bit.sv
// ss_decoder_5bit: rebuilds a binary estimate (mean symbol x 2^FRAC_W) from a window of stochastic symbols
module ss_decoder_5bit #(
  parameter int SYM_W    = 5,
  parameter int SYM_MAX  = 16,
  parameter int OUT_W    = 12,
  parameter int FRAC_W   = 8,
  parameter int LOG2_WIN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SYM_W-1:0] sym_in,
  input  logic             sym_valid,
  output logic             sym_ready,
  output logic [OUT_W-1:0] z_out,
  output logic             z_valid,
  input  logic             z_ready,
  output logic             busy,
  output logic             sat,
  output logic             sym_err
);
  localparam int ACC_W = SYM_W + LOG2_WIN;
  localparam int RAW_W = (SYM_W + FRAC_W > OUT_W) ? SYM_W + FRAC_W : OUT_W + 1;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d, acc_nx;
  logic [LOG2_WIN-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0]    z_q, z_d;
  logic                sat_q, sat_d, err_q, err_d, zv_q, zv_d;
  logic                over, accept, restart;
  logic [RAW_W-1:0]    raw;
  assign sym_ready = state_q == ACCUM;
  assign busy      = state_q != IDLE;
  assign accept    = sym_ready && sym_valid;
  assign over      = sym_in > SYM_W'(SYM_MAX);
  assign acc_nx    = acc_q + ACC_W'(over ? SYM_W'(SYM_MAX) : sym_in);
  assign raw       = RAW_W'(acc_nx) << (FRAC_W - LOG2_WIN);
  assign restart   = start && (state_q == IDLE || (state_q == DONE && z_ready));
  assign z_out     = z_q;
  assign sat       = sat_q;
  assign sym_err   = err_q;
  assign z_valid   = zv_q;
  // next state: open a window, accumulate clamped symbols, latch the decode on the final accept
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    sat_d   = sat_q;
    err_d   = err_q;
    if (restart) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else if (state_q == DONE && z_ready) begin
      state_d = IDLE;
    end else if (accept) begin
      acc_d = acc_nx;
      cnt_d = cnt_q + 1'b1;
      err_d = err_q | over;
      if (&cnt_q) begin
        state_d = DONE;
        sat_d   = raw > RAW_W'({OUT_W{1'b1}});
        z_d     = sat_d ? '1 : raw[OUT_W-1:0];
      end
    end
    zv_d = state_d == DONE;
  end
  // state and result registers; reset discards any partial window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
      zv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
      zv_q    <= zv_d;
    end
  end
endmodule
